// File: rtl/user_obi_dma.sv
// Multi-channel OBI word-copy engine: config subordinate port plus one shared manager
// port, serving busy channels one word at a time in round-robin order.
module user_obi_dma #(
  parameter int NumChannels = 4,
  parameter int LenWidth    = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   obi_sbr_req_i,
  input  logic                   obi_sbr_we_i,
  input  logic [ADDR_WIDTH-1:0]  obi_sbr_addr_i,
  input  logic [DATA_WIDTH-1:0]  obi_sbr_wdata_i,
  input  logic [3:0]             obi_sbr_be_i,
  output logic                   obi_sbr_gnt_o,
  output logic                   obi_sbr_rvalid_o,
  output logic [DATA_WIDTH-1:0]  obi_sbr_rdata_o,
  output logic                   obi_mgr_req_o,
  output logic                   obi_mgr_we_o,
  output logic [ADDR_WIDTH-1:0]  obi_mgr_addr_o,
  output logic [DATA_WIDTH-1:0]  obi_mgr_wdata_o,
  output logic [3:0]             obi_mgr_be_o,
  input  logic                   obi_mgr_gnt_i,
  input  logic                   obi_mgr_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  obi_mgr_rdata_i,
  output logic [NumChannels-1:0] irq_o
);
  localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_e;

  state_e                 state_r, state_n_s;
  logic [ChW-1:0]         cur_ch_r, rr_ptr_r, pick_ch_s, cand_s;
  logic                   pick_valid_s;
  logic [DATA_WIDTH-1:0]  data_r;
  logic                   wr_done_s;

  logic [ADDR_WIDTH-1:0]  src_r [NumChannels];
  logic [ADDR_WIDTH-1:0]  dst_r [NumChannels];
  logic [LenWidth-1:0]    rem_r [NumChannels];
  logic [NumChannels-1:0] busy_r, irq_en_r, done_r, aborted_r, abort_pend_r;
  logic [NumChannels-1:0] elig_s, active_s;

  logic [2:0]             cfg_ch_s;
  logic [1:0]             cfg_reg_s;
  logic [ChW-1:0]         cfg_idx_s;
  logic                   cfg_hit_s, cfg_wr_s;
  logic [ADDR_WIDTH-1:0]  cfg_addr_val_s;
  logic [DATA_WIDTH-1:0]  rd_data_s;
  logic                   sbr_rvalid_r;
  logic [DATA_WIDTH-1:0]  sbr_rdata_r;
  logic                   unused_s;

  assign cfg_ch_s       = obi_sbr_addr_i[6:4];
  assign cfg_reg_s      = obi_sbr_addr_i[3:2];
  assign cfg_idx_s      = cfg_ch_s[ChW-1:0];
  assign cfg_hit_s      = int'(cfg_ch_s) < NumChannels;
  assign cfg_wr_s       = obi_sbr_req_i && obi_sbr_we_i && cfg_hit_s;
  assign cfg_addr_val_s = ADDR_WIDTH'({obi_sbr_wdata_i[DATA_WIDTH-1:2], 2'b00});
  assign wr_done_s      = (state_r == WR_WAIT) && obi_mgr_rvalid_i;
  assign unused_s       = ^{obi_sbr_be_i, obi_sbr_addr_i[ADDR_WIDTH-1:7], obi_sbr_addr_i[1:0]};

  // Config read mux: live channel state, zero for unimplemented channels
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (cfg_hit_s) begin
      case (cfg_reg_s)
        2'd0:    rd_data_s = DATA_WIDTH'(src_r[cfg_idx_s]);
        2'd1:    rd_data_s = DATA_WIDTH'(dst_r[cfg_idx_s]);
        2'd2:    rd_data_s = DATA_WIDTH'(rem_r[cfg_idx_s]);
        2'd3:    rd_data_s = DATA_WIDTH'({aborted_r[cfg_idx_s], done_r[cfg_idx_s],
                                          irq_en_r[cfg_idx_s], busy_r[cfg_idx_s]});
        default: rd_data_s = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Subordinate response: one-cycle rvalid for every granted access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbr_rvalid_r <= 1'b0;
      sbr_rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      sbr_rvalid_r <= obi_sbr_req_i;
      sbr_rdata_r  <= (obi_sbr_req_i && !obi_sbr_we_i) ? rd_data_s : {DATA_WIDTH{1'b0}};
    end
  end

  // Channel eligibility and which channel currently owns the manager port
  always_comb begin
    elig_s   = {NumChannels{1'b0}};
    active_s = {NumChannels{1'b0}};
    for (int c = 0; c < NumChannels; c++) begin
      active_s[c] = (state_r != IDLE) && (cur_ch_r == ChW'(c));
      elig_s[c]   = busy_r[c] && (rem_r[c] != {LenWidth{1'b0}}) && !abort_pend_r[c];
    end
  end

  // Round-robin pick starting at rr_ptr_r (the channel after the last one served)
  always_comb begin
    pick_valid_s = 1'b0;
    pick_ch_s    = rr_ptr_r;
    cand_s       = {ChW{1'b0}};
    for (int i = 0; i < NumChannels; i++) begin
      cand_s = ChW'((int'(rr_ptr_r) + i) % NumChannels);
      if (!pick_valid_s && elig_s[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_ch_s    = cand_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Manager FSM next state: one outstanding transaction at a time
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE:    if (pick_valid_s)     state_n_s = RD_REQ;  else state_n_s = IDLE;
      RD_REQ:  if (obi_mgr_gnt_i)    state_n_s = RD_WAIT; else state_n_s = RD_REQ;
      RD_WAIT: if (obi_mgr_rvalid_i) state_n_s = WR_REQ;  else state_n_s = RD_WAIT;
      WR_REQ:  if (obi_mgr_gnt_i)    state_n_s = WR_WAIT; else state_n_s = WR_REQ;
      WR_WAIT: if (obi_mgr_rvalid_i) state_n_s = IDLE;    else state_n_s = WR_WAIT;
      default: state_n_s = IDLE;
    endcase
  end

  // Manager FSM state, served channel, RR pointer and read-data holding register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      cur_ch_r <= {ChW{1'b0}};
      rr_ptr_r <= {ChW{1'b0}};
      data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_n_s;
      if (state_r == IDLE && pick_valid_s) begin
        cur_ch_r <= pick_ch_s;
        rr_ptr_r <= (pick_ch_s == ChW'(NumChannels - 1)) ? {ChW{1'b0}} : pick_ch_s + ChW'(1);
      end
      if (state_r == RD_WAIT && obi_mgr_rvalid_i) begin
        data_r <= obi_mgr_rdata_i;
      end
    end
  end

  // Per-channel registers; completion events come after DONE_CLR so a same-cycle set wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        src_r[c] <= {ADDR_WIDTH{1'b0}};
        dst_r[c] <= {ADDR_WIDTH{1'b0}};
        rem_r[c] <= {LenWidth{1'b0}};
      end
      busy_r       <= {NumChannels{1'b0}};
      irq_en_r     <= {NumChannels{1'b0}};
      done_r       <= {NumChannels{1'b0}};
      aborted_r    <= {NumChannels{1'b0}};
      abort_pend_r <= {NumChannels{1'b0}};
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (cfg_wr_s && (cfg_idx_s == ChW'(c))) begin
          case (cfg_reg_s)
            2'd0: if (!busy_r[c]) src_r[c] <= cfg_addr_val_s;
            2'd1: if (!busy_r[c]) dst_r[c] <= cfg_addr_val_s;
            2'd2: if (!busy_r[c]) rem_r[c] <= obi_sbr_wdata_i[LenWidth-1:0];
            2'd3: begin
              irq_en_r[c] <= obi_sbr_wdata_i[1];
              if (obi_sbr_wdata_i[2]) done_r[c] <= 1'b0;
              if (busy_r[c]) begin
                if (obi_sbr_wdata_i[3]) abort_pend_r[c] <= 1'b1;
              end else if (obi_sbr_wdata_i[0] && obi_sbr_wdata_i[3]) begin
                aborted_r[c] <= 1'b1;
                done_r[c]    <= 1'b1;
              end else if (obi_sbr_wdata_i[0]) begin
                busy_r[c]       <= 1'b1;
                done_r[c]       <= 1'b0;
                aborted_r[c]    <= 1'b0;
                abort_pend_r[c] <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        // Zero-length start or abort on a channel with no word in flight
        if (busy_r[c] && !active_s[c] && ((rem_r[c] == {LenWidth{1'b0}}) || abort_pend_r[c])) begin
          busy_r[c]       <= 1'b0;
          done_r[c]       <= 1'b1;
          aborted_r[c]    <= abort_pend_r[c];
          abort_pend_r[c] <= 1'b0;
        end
        if (wr_done_s && (cur_ch_r == ChW'(c))) begin
          src_r[c] <= src_r[c] + ADDR_WIDTH'(4);
          dst_r[c] <= dst_r[c] + ADDR_WIDTH'(4);
          rem_r[c] <= rem_r[c] - LenWidth'(1);
          if ((rem_r[c] == LenWidth'(1)) || abort_pend_r[c]) begin
            busy_r[c]       <= 1'b0;
            done_r[c]       <= 1'b1;
            aborted_r[c]    <= abort_pend_r[c];
            abort_pend_r[c] <= 1'b0;
          end
        end
      end
    end
  end

  assign obi_sbr_gnt_o    = obi_sbr_req_i;
  assign obi_sbr_rvalid_o = sbr_rvalid_r;
  assign obi_sbr_rdata_o  = sbr_rdata_r;
  assign obi_mgr_req_o    = (state_r == RD_REQ) || (state_r == WR_REQ);
  assign obi_mgr_we_o     = (state_r == WR_REQ);
  assign obi_mgr_addr_o   = (state_r == RD_REQ) ? src_r[cur_ch_r] :
                            (state_r == WR_REQ) ? dst_r[cur_ch_r] : {ADDR_WIDTH{1'b0}};
  assign obi_mgr_wdata_o  = (state_r == WR_REQ) ? data_r : {DATA_WIDTH{1'b0}};
  assign obi_mgr_be_o     = obi_mgr_req_o ? 4'hF : 4'h0;
  assign irq_o            = done_r & irq_en_r;

endmodule

// File: tb/tb_user_obi_dma.sv
// Directed bench for user_obi_dma: config-port driver, stalling memory slave on the
// manager port, and hand-computed expectations per scenario.
module tb_user_obi_dma;
  localparam logic [31:0] KEY = 32'hC3A5_5A3C;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sbr_req, sbr_we, sbr_gnt, sbr_rvalid;
  logic [31:0] sbr_addr, sbr_wdata, sbr_rdata;
  logic [3:0]  sbr_be;
  logic        mgr_req, mgr_we, mgr_gnt, mgr_rvalid;
  logic [31:0] mgr_addr, mgr_wdata, mgr_rdata;
  logic [3:0]  mgr_be;
  logic [3:0]  irq;

  always #5 clk = ~clk;

  user_obi_dma dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_sbr_req_i(sbr_req), .obi_sbr_we_i(sbr_we), .obi_sbr_addr_i(sbr_addr),
    .obi_sbr_wdata_i(sbr_wdata), .obi_sbr_be_i(sbr_be), .obi_sbr_gnt_o(sbr_gnt),
    .obi_sbr_rvalid_o(sbr_rvalid), .obi_sbr_rdata_o(sbr_rdata),
    .obi_mgr_req_o(mgr_req), .obi_mgr_we_o(mgr_we), .obi_mgr_addr_o(mgr_addr),
    .obi_mgr_wdata_o(mgr_wdata), .obi_mgr_be_o(mgr_be), .obi_mgr_gnt_i(mgr_gnt),
    .obi_mgr_rvalid_i(mgr_rvalid), .obi_mgr_rdata_i(mgr_rdata), .irq_o(irq)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Memory behind the manager port; unwritten words read as address ^ KEY
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_addr [$];
  logic        log_we [$];
  int          wr_count = 0;
  int          max_stall = 0;
  int          proto_err = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ KEY;
  endfunction

  // Manager-side slave with random grant/response delays and hold checking
  initial begin : slave
    logic [31:0] a, d;
    logic        w;
    int          k;
    mgr_gnt = 1'b0; mgr_rvalid = 1'b0; mgr_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mgr_req && rst_ni) begin
        a = mgr_addr; w = mgr_we; d = mgr_wdata;
        if (mgr_be !== 4'hF) proto_err++;
        k = $urandom_range(max_stall, 0);
        repeat (k) begin
          @(posedge clk); #1;
          if (rst_ni && (mgr_req !== 1'b1 || mgr_addr !== a || mgr_we !== w || (w && mgr_wdata !== d)))
            proto_err++;
        end
        mgr_gnt = 1'b1;
        @(posedge clk); #1;
        mgr_gnt = 1'b0;
        log_addr.push_back(a); log_we.push_back(w);
        if (w) begin mem[a] = d; wr_count++; end
        k = $urandom_range(max_stall, 0);
        repeat (k) begin @(posedge clk); #1; end
        mgr_rvalid = 1'b1;
        mgr_rdata  = w ? 32'h0 : mem_rd(a);
        @(posedge clk); #1;
        mgr_rvalid = 1'b0; mgr_rdata = 32'h0;
      end
    end
  end

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'(ch * 16 + r * 4);
  endfunction

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    sbr_req = 1'b1; sbr_we = 1'b1; sbr_addr = a; sbr_wdata = d;
    @(posedge clk); #1;
    sbr_req = 1'b0; sbr_we = 1'b0;
  endtask

  task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
    sbr_req = 1'b1; sbr_we = 1'b0; sbr_addr = a;
    @(posedge clk); #1;
    sbr_req = 1'b0;
    d = sbr_rdata;
  endtask

  task automatic wait_done(input int ch, input int budget, input string tag);
    logic [31:0] v;
    int n = 0;
    do begin cfg_rd(ra(ch, 3), v); n++; end while (!v[2] && n < budget);
    if (!v[2]) check({tag, "_timeout"}, v, 32'h4);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); wr_count = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] v;
    logic [31:0] exp_rd [6];
    int k, w, n;
    sbr_req = 1'b0; sbr_we = 1'b0; sbr_addr = 32'h0; sbr_wdata = 32'h0; sbr_be = 4'hF;
    repeat (3) @(posedge clk); #1;
    check("rst_mgr_req", mgr_req, 32'h0);
    check("rst_mgr_be", mgr_be, 32'h0);
    check("rst_irq", irq, 32'h0);
    check("rst_sbr_rvalid", sbr_rvalid, 32'h0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    cfg_rd(ra(0, 3), v);
    check("rst_ctrl", v, 32'h0);
    check("sbr_rvalid", sbr_rvalid, 32'h1);

    // Address alignment and unimplemented channel
    cfg_wr(ra(2, 0), 32'h0000_1003);
    cfg_rd(ra(2, 0), v); check("src_align", v, 32'h0000_1000);
    cfg_wr(ra(5, 0), 32'h0000_1234);
    cfg_rd(ra(5, 0), v); check("oob_rd", v, 32'h0);
    cfg_rd(ra(1, 0), v); check("oob_noalias", v, 32'h0);

    // T1 single channel copy with interrupt
    clear_log();
    cfg_wr(ra(0, 0), 32'h1000); cfg_wr(ra(0, 1), 32'h2000); cfg_wr(ra(0, 2), 32'd4);
    cfg_wr(ra(0, 3), 32'h3);
    wait_done(0, 200, "t1");
    check("t1_ntxn", log_addr.size(), 32'd8);
    for (int i = 0; i < 4 && 2 * i + 1 < log_addr.size(); i++) begin
      check("t1_rd_addr", log_addr[2 * i], 32'h1000 + 32'(4 * i));
      check("t1_wr_addr", log_addr[2 * i + 1], 32'h2000 + 32'(4 * i));
      check("t1_data", mem_rd(32'h2000 + 32'(4 * i)), (32'h1000 + 32'(4 * i)) ^ KEY);
    end
    check("t1_irq", irq, 32'h1);
    cfg_rd(ra(0, 3), v); check("t1_ctrl", v, 32'h6);
    cfg_rd(ra(0, 0), v); check("t1_src_live", v, 32'h1010);
    cfg_rd(ra(0, 2), v); check("t1_len_live", v, 32'h0);

    // T2 two channels interleave word by word
    clear_log();
    cfg_wr(ra(0, 0), 32'h3000); cfg_wr(ra(0, 1), 32'h4000); cfg_wr(ra(0, 2), 32'd3);
    cfg_wr(ra(1, 0), 32'h5000); cfg_wr(ra(1, 1), 32'h6000); cfg_wr(ra(1, 2), 32'd3);
    cfg_wr(ra(0, 3), 32'h1); cfg_wr(ra(1, 3), 32'h1);
    wait_done(0, 300, "t2_ch0"); wait_done(1, 300, "t2_ch1");
    exp_rd = '{32'h3000, 32'h5000, 32'h3004, 32'h5004, 32'h3008, 32'h5008};
    k = 0;
    for (int j = 0; j < log_addr.size(); j++) begin
      if (!log_we[j]) begin
        if (k < 6) check($sformatf("t2_order%0d", k), log_addr[j], exp_rd[k]);
        k++;
      end
    end
    check("t2_nrd", k, 32'd6);
    cfg_rd(ra(0, 3), v); check("t2_ctrl0", v, 32'h4);
    cfg_rd(ra(1, 3), v); check("t2_ctrl1", v, 32'h4);
    check("t2_irq", irq, 32'h0);
    check("t2_data", mem_rd(32'h6008), 32'h5008 ^ KEY);

    // T3 zero-length start, interrupt and clear timing
    clear_log();
    cfg_wr(ra(2, 2), 32'd0);
    cfg_wr(ra(2, 3), 32'h3);
    check("t3_irq_pre", irq[2], 32'h0);
    @(posedge clk); #1;
    check("t3_irq", irq[2], 32'h1);
    repeat (10) @(posedge clk); #1;
    check("t3_nomgr", log_addr.size(), 32'd0);
    cfg_wr(ra(2, 3), 32'h6);
    check("t3_irq_clr", irq[2], 32'h0);
    cfg_rd(ra(2, 3), v); check("t3_ctrl", v, 32'h2);

    // START and ABORT together on an idle channel
    cfg_wr(ra(2, 2), 32'd5);
    cfg_wr(ra(2, 3), 32'h9);
    repeat (10) @(posedge clk); #1;
    check("sa_nomgr", log_addr.size(), 32'd0);
    cfg_rd(ra(2, 3), v); check("sa_ctrl", v, 32'hC);
    cfg_rd(ra(2, 2), v); check("sa_len", v, 32'd5);

    // T4 abort mid-transfer
    clear_log();
    cfg_wr(ra(3, 0), 32'h7000); cfg_wr(ra(3, 1), 32'h8000); cfg_wr(ra(3, 2), 32'd100);
    cfg_wr(ra(3, 3), 32'h1);
    n = 0;
    while (wr_count < 5 && n < 500) begin @(posedge clk); #1; n++; end
    check("t4_reach5", wr_count >= 5, 32'h1);
    cfg_wr(ra(3, 0), 32'hDEAD_0000);
    cfg_wr(ra(3, 3), 32'h8);
    wait_done(3, 300, "t4");
    w = wr_count;
    check("t4_words", (w == 5 || w == 6), 32'h1);
    cfg_rd(ra(3, 3), v); check("t4_ctrl", v, 32'hC);
    cfg_rd(ra(3, 2), v); check("t4_len", v, 32'(100 - w));
    cfg_rd(ra(3, 0), v); check("t4_src", v, 32'h7000 + 32'(4 * w));
    for (int i = 0; i < w; i++)
      check("t4_data", mem_rd(32'h8000 + 32'(4 * i)), (32'h7000 + 32'(4 * i)) ^ KEY);

    // T5 random stalls
    clear_log();
    max_stall = 7; proto_err = 0;
    cfg_wr(ra(1, 0), 32'h9000); cfg_wr(ra(1, 1), 32'hA000); cfg_wr(ra(1, 2), 32'd8);
    cfg_wr(ra(1, 3), 32'h1);
    wait_done(1, 2000, "t5");
    max_stall = 0;
    check("t5_hold", proto_err, 32'd0);
    check("t5_ntxn", log_addr.size(), 32'd16);
    for (int i = 0; i < 8; i++)
      check("t5_data", mem_rd(32'hA000 + 32'(4 * i)), (32'h9000 + 32'(4 * i)) ^ KEY);
    cfg_rd(ra(1, 3), v); check("t5_ctrl", v, 32'h4);

    // T6 address wrap, then reset mid-copy
    clear_log();
    cfg_wr(ra(0, 0), 32'hFFFF_FFF8); cfg_wr(ra(0, 1), 32'hB000); cfg_wr(ra(0, 2), 32'd3);
    cfg_wr(ra(0, 3), 32'h1);
    wait_done(0, 200, "t6");
    exp_rd[0] = 32'hFFFF_FFF8; exp_rd[1] = 32'hFFFF_FFFC; exp_rd[2] = 32'h0000_0000;
    k = 0;
    for (int j = 0; j < log_addr.size(); j++) begin
      if (!log_we[j]) begin
        if (k < 3) check($sformatf("t6_wrap%0d", k), log_addr[j], exp_rd[k]);
        k++;
      end
    end
    check("t6_nrd", k, 32'd3);
    cfg_rd(ra(0, 0), v); check("t6_src_wrap", v, 32'h4);
    check("t6_data", mem_rd(32'hB008), 32'h0 ^ KEY);

    cfg_wr(ra(0, 0), 32'hC000); cfg_wr(ra(0, 1), 32'hD000); cfg_wr(ra(0, 2), 32'd50);
    cfg_wr(ra(0, 3), 32'h3);
    repeat (10) @(posedge clk); #1;
    n = 0;
    while (!(mgr_req && mgr_we) && n < 100) begin @(posedge clk); #1; n++; end
    check("t6_midcopy", mgr_req && mgr_we, 32'h1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_req", mgr_req, 32'h0);
    check("t6_rst_addr", mgr_addr, 32'h0);
    check("t6_rst_wdata", mgr_wdata, 32'h0);
    check("t6_rst_misc", {mgr_we, mgr_be, sbr_gnt, sbr_rvalid, irq}, 32'h0);
    check("t6_rst_rdata", sbr_rdata, 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (10) @(posedge clk); #1;
    cfg_rd(ra(0, 3), v); check("t6_post_ctrl", v, 32'h0);
    cfg_rd(ra(0, 0), v); check("t6_post_src", v, 32'h0);
    check("t6_post_req", mgr_req, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
